// File: rtl/stack_bram_mf.sv
// Multi-frame stack memory. NUM_FRAMES independent frames share one
// simple-dual-port BRAM. Per-frame entry counts live in registers. A frame can
// be streamed in ascending order without consuming it, or popped LIFO.
// The output side has valid/ready backpressure through a 2-entry buffer.
module stack_bram_mf #(
    parameter int DATA_WIDTH  = 10,
    parameter int NUM_FRAMES  = 4,
    parameter int FRAME_DEPTH = 128,
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    localparam int CW = $clog2(FRAME_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push_en,
    input  logic [FW-1:0]         push_frame,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  start,
    input  logic [FW-1:0]         start_frame,
    input  logic                  mode,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy,
    output logic                  done,
    input  logic [FW-1:0]         count_sel,
    output logic [CW-1:0]         count_out,
    output logic [NUM_FRAMES-1:0] full,
    output logic [NUM_FRAMES-1:0] empty,
    output logic                  err
);

    localparam int DEPTH = NUM_FRAMES * FRAME_DEPTH;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [CW-1:0] FULL_CNT = CW'(FRAME_DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]         cnt [NUM_FRAMES];

    logic [1:0]            state;
    logic [FW-1:0]         frame_q;
    logic                  mode_q;
    logic [CW-1:0]         n_q;
    logic [CW-1:0]         rd_cnt;

    // Output buffer: slot 0 is the head driving dout, slot 1 is the skid entry.
    logic [DATA_WIDTH-1:0] buf0_p1;
    logic [DATA_WIDTH-1:0] buf1_p1;
    logic                  vld0_p1;
    logic                  vld1_p1;

    logic                  pop;
    logic                  room;
    logic                  rd_en;
    logic                  last_read;
    logic                  push_ok;
    logic                  drain_empty;
    logic [CW-1:0]         rd_idx;
    logic [AW-1:0]         rd_addr;
    logic [AW-1:0]         push_addr;

    for (genvar f = 0; f < NUM_FRAMES; f++) begin : g_flags
        assign full[f]  = (cnt[f] == FULL_CNT);
        assign empty[f] = (cnt[f] == '0);
    end

    assign count_out  = cnt[count_sel];
    assign busy       = (state != S_IDLE);
    assign dout       = buf0_p1;
    assign dout_valid = vld0_p1;

    // A read may be issued whenever the buffer is guaranteed a free slot at
    // the end of this cycle, i.e. it is not holding two entries or one leaves.
    assign pop       = vld0_p1 & dout_ready;
    assign room      = ~vld1_p1 | pop;
    assign rd_en     = (state == S_READ) & room;
    assign rd_idx    = mode_q ? (n_q - CW'(1) - rd_cnt) : rd_cnt;
    assign rd_addr   = AW'(frame_q) * AW'(FRAME_DEPTH) + AW'(rd_idx);
    assign last_read = rd_en & (rd_cnt == n_q - CW'(1));

    // The frame currently being streamed is locked against pushes so the
    // latched length stays consistent with memory contents.
    assign push_ok   = push_en & ~clr & ~full[push_frame]
                     & ~(busy & (push_frame == frame_q));
    assign push_addr = AW'(push_frame) * AW'(FRAME_DEPTH) + AW'(cnt[push_frame]);

    // Buffer will hold nothing after this cycle's handshake.
    assign drain_empty = ~vld0_p1 | (pop & ~vld1_p1);

    // BRAM write port; contents survive reset and clear.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[push_addr] <= din;
        end
    end

    // Per-frame counts: increment on accepted push, decrement on LIFO handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < NUM_FRAMES; f++) cnt[f] <= '0;
        end else if (clr) begin
            for (int f = 0; f < NUM_FRAMES; f++) cnt[f] <= '0;
        end else begin
            if (push_ok) begin
                cnt[push_frame] <= cnt[push_frame] + CW'(1);
            end
            if (pop & mode_q) begin
                cnt[frame_q] <= cnt[frame_q] - CW'(1);
            end
        end
    end

    // Sticky error flag for rejected pushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (clr) begin
            err <= 1'b0;
        end else if (push_en & ~push_ok) begin
            err <= 1'b1;
        end
    end

    // Stream control FSM: latch the request, issue reads, wait for drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            done    <= 1'b0;
            frame_q <= '0;
            mode_q  <= 1'b0;
            n_q     <= '0;
            rd_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                state  <= S_IDLE;
                rd_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (cnt[start_frame] != '0) begin
                                frame_q <= start_frame;
                                mode_q  <= mode;
                                n_q     <= cnt[start_frame];
                                rd_cnt  <= '0;
                                state   <= S_READ;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    S_READ: begin
                        if (rd_en) begin
                            rd_cnt <= rd_cnt + CW'(1);
                            if (last_read) begin
                                state <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (drain_empty) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Output buffer: BRAM read data lands directly in the first free slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf0_p1 <= '0;
            buf1_p1 <= '0;
            vld0_p1 <= 1'b0;
            vld1_p1 <= 1'b0;
        end else if (clr) begin
            buf0_p1 <= '0;
            buf1_p1 <= '0;
            vld0_p1 <= 1'b0;
            vld1_p1 <= 1'b0;
        end else begin
            case ({rd_en, pop})
                2'b11: begin
                    if (vld1_p1) begin
                        buf0_p1 <= buf1_p1;
                        buf1_p1 <= mem[rd_addr];
                    end else begin
                        buf0_p1 <= mem[rd_addr];
                    end
                end
                2'b01: begin
                    buf0_p1 <= vld1_p1 ? buf1_p1 : '0;
                    vld0_p1 <= vld1_p1;
                    vld1_p1 <= 1'b0;
                end
                2'b10: begin
                    if (!vld0_p1) begin
                        buf0_p1 <= mem[rd_addr];
                        vld0_p1 <= 1'b1;
                    end else begin
                        buf1_p1 <= mem[rd_addr];
                        vld1_p1 <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
